// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path.
//   rx_state_t : receiver FSM state encoding
//   cnt_width  : counter width able to hold values 0..max_val-1 (minimum 1)
//   parity_of  : XOR reduction used for the optional even-parity check
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  function automatic int cnt_width(input int max_val);
    if (max_val < 2) begin
      return 1;
    end else begin
      return $clog2(max_val);
    end
  endfunction

  // Odd number of ones yields 1; an even-parity frame reduces to 0.
  function automatic logic parity_of(input logic [15:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write request and data (accepted when not full, or full with a pop)
//   pop           read request (ignored while empty)
//   rdata         head entry, combinational from the storage array
//   full, empty   occupancy flags
//   count         occupancy 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = cnt_width(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_pop_s;
  logic             do_push_s;

  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == {(AW+1){1'b0}});
  assign count = count_r;
  assign rdata = mem_r[rd_ptr_r];

  // A pop needs data; a push into a full FIFO is fine when the head leaves in the same cycle
  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
  end

  // Storage array; cleared on reset so the head reads 0 while empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Read/write pointers and occupancy counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (start + DATA_BITS LSB-first + stop) feeding a
// show-ahead receive FIFO drained through a valid/ready interface.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit after the
// data bits and the parity_err_o output.
// Ports:
//   clk          system clock
//   reset_i      asynchronous active-high reset
//   rx_i         asynchronous serial input, idle high
//   data_o       FIFO head, meaningful while valid_o = 1
//   valid_o      FIFO not empty
//   ready_i      consumer accepts the head (pop on valid_o & ready_i)
//   count_o      FIFO occupancy
//   frame_err_o  one-cycle pulse: stop bit low, frame discarded
//   overrun_o    one-cycle pulse: frame completed into a full FIFO, dropped
//   parity_err_o one-cycle pulse: parity mismatch, frame discarded (macro only)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        reset_i,
  input  logic                        rx_i,
  output logic [DATA_BITS-1:0]        data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        frame_err_o,
`ifdef UART_RX_PARITY_EN
  output logic                        parity_err_o,
`endif
  output logic                        overrun_o
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int BW = cnt_width(DATA_BITS);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 sync1_r;
  logic                 sync2_r;
  rx_state_t            state_r;
  rx_state_t            state_next_s;
  logic [CW-1:0]        clk_cnt_r;
  logic [BW-1:0]        bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 tick_s;
  logic                 stop_tick_s;
  logic                 par_fail_s;
  logic                 frame_ok_s;
  logic                 frame_err_s;
  logic                 overrun_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_r;
`endif

  assign tick_s = (clk_cnt_r == {CW{1'b0}});

  // Two-flop synchroniser; resets to the idle line level
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx_i;
      sync2_r <= sync1_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; STOP goes straight back to IDLE so back-to-back frames are caught
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!sync2_r) begin
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          // A start bit that is high again at mid-bit was a glitch
          state_next_s = sync2_r ? IDLE : DATA;
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (tick_s && (bit_cnt_r == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
          state_next_s = PARITY;
`else
          state_next_s = STOP;
`endif
        end else begin
          state_next_s = DATA;
        end
      end
      PARITY: begin
        if (tick_s) begin
          state_next_s = STOP;
        end else begin
          state_next_s = PARITY;
        end
      end
      STOP: begin
        if (tick_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = STOP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Bit-timing counter, bit index and LSB-first shift register
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      clk_cnt_r <= {CW{1'b0}};
      bit_cnt_r <= {BW{1'b0}};
      shift_r   <= {DATA_BITS{1'b0}};
`ifdef UART_RX_PARITY_EN
      par_bit_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (!sync2_r) begin
            clk_cnt_r <= HALF_LOAD;
            bit_cnt_r <= {BW{1'b0}};
          end
        end
        START: begin
          if (tick_s) begin
            clk_cnt_r <= FULL_LOAD;
            bit_cnt_r <= {BW{1'b0}};
          end else begin
            clk_cnt_r <= clk_cnt_r - CW'(1);
          end
        end
        DATA: begin
          if (tick_s) begin
            shift_r   <= {sync2_r, shift_r[DATA_BITS-1:1]};
            clk_cnt_r <= FULL_LOAD;
            bit_cnt_r <= bit_cnt_r + BW'(1);
          end else begin
            clk_cnt_r <= clk_cnt_r - CW'(1);
          end
        end
        PARITY: begin
          if (tick_s) begin
`ifdef UART_RX_PARITY_EN
            par_bit_r <= sync2_r;
`endif
            clk_cnt_r <= FULL_LOAD;
          end else begin
            clk_cnt_r <= clk_cnt_r - CW'(1);
          end
        end
        STOP: begin
          if (!tick_s) begin
            clk_cnt_r <= clk_cnt_r - CW'(1);
          end
        end
        default: clk_cnt_r <= {CW{1'b0}};
      endcase
    end
  end

  // FSM outputs: frame disposition decided at the stop-bit sample; parity error wins over stop error
  always_comb begin
    stop_tick_s = (state_r == STOP) && tick_s;
`ifdef UART_RX_PARITY_EN
    par_fail_s  = stop_tick_s & (parity_of({{(16-DATA_BITS){1'b0}}, shift_r}) ^ par_bit_r);
`else
    par_fail_s  = 1'b0;
`endif
    frame_ok_s  = stop_tick_s & ~par_fail_s & sync2_r;
    frame_err_s = stop_tick_s & ~par_fail_s & ~sync2_r;
    // A full FIFO still takes the frame if the head is popped in the same cycle
    overrun_s   = frame_ok_s & fifo_full_s & ~(ready_i & ~fifo_empty_s);
  end

  // Error pulses registered so they line up with the pushed data
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
    end else begin
      frame_err_o  <= frame_err_s;
      overrun_o    <= overrun_s;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= par_fail_s;
`endif
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset_i),
    .push  (frame_ok_s),
    .pop   (ready_i),
    .wdata (shift_r),
    .rdata (data_o),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (count_o)
  );

  assign valid_o = ~fifo_empty_s;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo (CLKS_PER_BIT=8,
// DATA_BITS=8, FIFO_DEPTH=4). Stimulus predicts each frame's fate from the
// frame-level rules (good frame -> queued byte, bad stop -> frame error,
// full FIFO without pop -> overrun) and a negedge monitor checks every
// handshake and every error pulse against those queues.
module tb_uart_rx_fifo;

  localparam int CPB   = 8;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef enum int {EV_FRAME = 0, EV_OVERRUN = 1, EV_PARITY = 2} ev_t;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          rx_i;
  logic          ready_i;
  logic [DB-1:0] data_o;
  logic          valid_o;
  logic [2:0]    count_o;
  logic          frame_err_o;
  logic          overrun_o;
`ifdef UART_RX_PARITY_EN
  logic          parity_err_o;
`endif

  int            errors = 0;
  int            checks = 0;
  logic [DB-1:0] exp_q[$];
  ev_t           ev_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .count_o      (count_o),
    .frame_err_o  (frame_err_o),
`ifdef UART_RX_PARITY_EN
    .parity_err_o (parity_err_o),
`endif
    .overrun_o    (overrun_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic ev_seen(input ev_t e, input string name);
    checks++;
    if (ev_q.size() == 0) begin
      errors++;
      $display("FAIL %s: pulse seen, none expected", name);
    end else begin
      if (ev_q[0] != e) begin
        errors++;
        $display("FAIL %s: pulse seen, expected event %0d", name, ev_q[0]);
      end
      ev_q.delete(0);
    end
  endtask

  // Monitor: handshakes pop the expected-data queue, pulses pop the event queue
  always @(negedge clk) begin
    if (!reset_i) begin
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_data: got %0h, expected no data", data_o);
        end else begin
          chk("pop_data", data_o, exp_q.pop_front());
        end
      end
      if (frame_err_o) ev_seen(EV_FRAME, "frame_err");
      if (overrun_o) ev_seen(EV_OVERRUN, "overrun");
`ifdef UART_RX_PARITY_EN
      if (parity_err_o) ev_seen(EV_PARITY, "parity_err");
`endif
      if (frame_err_o || overrun_o) chk("err_exclusive", frame_err_o & overrun_o, 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bit_period(input logic b);
    rx_i = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Frame-level reference: decides the fate of a frame just before its stop sample
  task automatic predict(input logic [DB-1:0] d, input logic stop, input logic par);
    if ((PAR != 0) && ((^d) ^ par)) begin
      ev_q.push_back(EV_PARITY);
    end else if (!stop) begin
      ev_q.push_back(EV_FRAME);
    end else if ((exp_q.size() == DEPTH) && !ready_i) begin
      ev_q.push_back(EV_OVERRUN);
    end else begin
      exp_q.push_back(d);
    end
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par,
                            input logic pop_at_stop);
    bit_period(1'b0);
    for (int i = 0; i < DB; i++) bit_period(d[i]);
    if (PAR != 0) bit_period(par);
    rx_i = stop;
    repeat (CPB-2) @(posedge clk);
    #1;
    if (pop_at_stop) ready_i = 1'b1;
    predict(d, stop, par);
    @(posedge clk);
    #1;
    if (pop_at_stop) ready_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, count_o, exp_q.size());
    chk({tag, "_valid"}, valid_o, exp_q.size() > 0);
    if (exp_q.size() > 0) chk({tag, "_head"}, data_o, exp_q[0]);
    chk({tag, "_events_pending"}, ev_q.size(), 0);
  endtask

  task automatic drain();
    ready_i = 1'b1;
    repeat (DEPTH + 2) @(posedge clk);
    #1;
    ready_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, count_o, 0);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_data"}, data_o, 0);
    chk({tag, "_frame_err"}, frame_err_o, 0);
    chk({tag, "_overrun"}, overrun_o, 0);
  endtask

  initial begin
    logic [DB-1:0] d;
    logic          stop;
    logic          par;

    reset_i = 1'b1;
    rx_i    = 1'b1;
    ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Single frame held, then one-cycle pop
    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0);
    check_state("a5");
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    check_state("a5_popped");

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    check_state("b2b");
    drain();
    check_state("b2b_drained");

    // Stop bit low
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    bit_period(1'b1);
    check_state("frame_err");

    // Short low glitch on the line
    rx_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_i = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check_state("glitch");

    // Fill, overrun, then full with a pop exactly at the stop sample
    for (int i = 1; i <= 5; i++) begin
      d = DB'(i);
      send_frame(d, 1'b1, ^d, 1'b0);
    end
    check_state("overrun");
    send_frame(8'h06, 1'b1, ^8'h06, 1'b1);
    check_state("full_pop");
    drain();
    check_state("full_drained");

    // Asynchronous reset in the middle of a data bit
    bit_period(1'b0);
    bit_period(1'b1);
    rx_i = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset_i = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    exp_q.delete();
    ev_q.delete();
    rx_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    send_frame(8'h7E, 1'b1, ^8'h7E, 1'b0);
    check_state("after_reset");
    drain();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1, 1'b0);
    check_state("parity_bad");
    send_frame(8'h03, 1'b1, 1'b0, 1'b0);
    check_state("parity_good");
    drain();
`endif

    // Randomised frames, stop errors, parity errors, consumer stalls and gaps
    for (int n = 0; n < 40; n++) begin
      d       = DB'($urandom_range(0, 255));
      stop    = ($urandom_range(0, 9) != 0);
      par     = (^d) ^ ($urandom_range(0, 9) == 0);
      ready_i = ($urandom_range(0, 2) == 0);
      send_frame(d, stop, par, 1'b0);
      check_state("rand");
      for (int g = $urandom_range(0, 2); g > 0; g--) bit_period(1'b1);
    end
    ready_i = 1'b0;
    drain();
    check_state("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
